std_lane_rx_buffer: RTL
=======================

// Module: std_lane_rx_buffer
// PURPOSE
//  Per-lane receive stage on the downstream stack bus. It sits between the stack-bus lane (std_lane) and the
//  PE stream-operation controller (stOp). It accepts framed lane words, checks SOD/MOD/EOD ordering and packet
//  length, and buffers legal words in a show-ahead FIFO. It applies backpressure upstream and keeps sticky error/status.
// PARAMETERS
//  DATA_WIDTH          32   lane data width
//  DEPTH               8    FIFO entries (power of 2, >=4)
//  AFULL_THRESH        6    occupancy at/above which upstream ready deasserts
//  MAX_PKT_LEN         256  max words per packet incl. SOD and EOD
// PORTS
//  clk                         in   1           clock
//  reset_poweron               in   1           asynchronous, active-low reset
//  std__pe__lane_strm_valid    in   1           upstream word valid
//  std__pe__lane_strm_cntl     in   2           framing: SOD=01 MOD=00 EOD=10 SOD_EOD=11
//  std__pe__lane_strm_data     in   DATA_WIDTH  upstream word
//  pe__std__lane_strm_ready    out  1           upstream may send (registered)
//  rx__stOp_strm_valid         out  1           FIFO head valid
//  rx__stOp_strm_cntl          out  2           FIFO head framing
//  rx__stOp_strm_data          out  DATA_WIDTH  FIFO head data
//  stOp__rx_strm_ready         in   1           downstream pops head when valid&ready
//  rx__pkt_count               out  16          complete packets accepted (EOD or SOD_EOD written), wraps
//  rx__framing_err             out  1           sticky framing/length error
//  rx__overflow_err            out  1           sticky word-dropped-while-full error
//  err_clear                   in   1           synchronous clear of both sticky errors
// BEHAVIOUR
//  Reset (async assert, sync deassert, all regs): FIFO empty, rd/wr ptrs 0, state IDLE, len 0, ready=0,
//   valid=0, cntl=0, data=0, pkt_count=0, both errs=0. ready rises the first clk after reset release.
//  Upstream: no ready/valid dependency. A word presents when valid=1. pe__std__lane_strm_ready is registered and
//   equals (occupancy < AFULL_THRESH). Upstream may send up to DEPTH-AFULL_THRESH words after ready falls.
//  Accept: word written iff valid & framing legal & (FIFO not full OR pop same cycle).
//   Full & valid & no pop -> word dropped, overflow_err<=1, FSM/len unchanged.
//  Latency: word accepted at edge N is visible on rx__stOp_* after edge N (show-ahead; 1-cycle through empty FIFO).
//  Downstream: valid = !empty. cntl/data = head entry. Pop when valid & ready. Simultaneous push+pop keeps occupancy.
//  FSM (advances only on accepted or dropped-illegal words; overflow-dropped words ignored):
//   IDLE:   SOD->write, len=1, IN_PKT | SOD_EOD->write, pkt_count++, IDLE | MOD/EOD->drop, framing_err<=1, IDLE
//   IN_PKT: MOD->write, len++ | EOD->write, pkt_count++, IDLE
//           SOD->framing_err<=1, write, len=1, stay IN_PKT (the unterminated packet is abandoned unterminated downstream)
//           SOD_EOD->framing_err<=1, write, pkt_count++, IDLE
//   Length: a MOD that would make len reach MAX_PKT_LEN (no room for EOD) -> framing_err<=1, write it re-tagged EOD,
//    pkt_count++, IDLE. Subsequent MOD/EOD then hit the IDLE illegal path.
//  Sticky errs: set has priority over err_clear in the same cycle.
//  pkt_count wraps 0xFFFF->0. len is clog2(MAX_PKT_LEN)+1 bits, no wrap possible.
//  Pointers are clog2(DEPTH)+1 bits, MSB compare for full/empty, wrap modulo 2*DEPTH.
//  Reset mid-packet: FIFO contents discarded, FSM IDLE. Downstream sees valid drop immediately (async).
// STRUCTURE
//  Shared package (pe_array_pkg): STD_CNTL_SOD/MOD/EOD/SOD_EOD localparams, typedef std_cntl_e, rx_state_e {IDLE,IN_PKT}.
//  Sub-module: std_lane_rx_fifo (generic show-ahead sync FIFO, DATA_WIDTH+2 wide, exports occupancy). Framing FSM,
//   length/pkt counters and ready register live in the top.
//  Connects via existing std_lane_ifc (upstream side) and a stOp-side lane interface.
// TESTING
//  1 Reset then SOD,MOD,MOD,EOD (data 1..4), stOp ready=1 -> 4 words out in order, cntl 01,00,00,10, pkt_count=1, errs 0.
//  2 stOp ready=0, stream 8 MODs in packet -> ready falls after occupancy 6. 9th word while full -> dropped, overflow_err=1.
//  3 IDLE, send MOD 0xA5 -> not written, framing_err=1. err_clear=1 -> 0. Next SOD_EOD -> output cntl 11, pkt_count++.
//  4 SOD, MOD, SOD, EOD -> framing_err=1, all 4 words output, pkt_count=1.
//  5 MAX_PKT_LEN=4: SOD,MOD,MOD,MOD,EOD -> 3rd MOD output re-tagged EOD, framing_err=1, final EOD dropped.
//  6 Full FIFO with push+pop same cycle -> both succeed, occupancy stays DEPTH. Assert reset mid-packet -> valid=0, ready=0.

Source files
------------

// File: rtl/pe_array_pkg.sv
// Shared lane framing codes and receive-FSM state type for the PE array.
package pe_array_pkg;

    // Lane framing codes carried on the 2-bit cntl field
    localparam logic [1:0] STD_CNTL_MOD     = 2'b00;
    localparam logic [1:0] STD_CNTL_SOD     = 2'b01;
    localparam logic [1:0] STD_CNTL_EOD     = 2'b10;
    localparam logic [1:0] STD_CNTL_SOD_EOD = 2'b11;

    typedef enum logic [1:0] {
        CntlMod    = STD_CNTL_MOD,
        CntlSod    = STD_CNTL_SOD,
        CntlEod    = STD_CNTL_EOD,
        CntlSodEod = STD_CNTL_SOD_EOD
    } std_cntl_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StInPkt = 1'b1
    } rx_state_e;

endpackage

// File: rtl/std_lane_rx_fifo.sv
// Generic show-ahead synchronous FIFO. Head entry is always presented on
// head_data; the caller guarantees no push when full without a pop and no
// pop when empty.
module std_lane_rx_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_poweron,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    // Storage and pointers; extra pointer MSB separates full from empty
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
                wr_ptr_q                <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    // Status and show-ahead head
    always_comb begin
        head_data = mem_q[rd_ptr_q[AW-1:0]];
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        occupancy = wr_ptr_q - rd_ptr_q;
    end

endmodule

// File: rtl/std_lane_rx_buffer.sv
// Per-lane receive stage: checks SOD/MOD/EOD ordering and packet length on
// incoming lane words, buffers legal words in a show-ahead FIFO for stOp,
// drives registered backpressure upstream and keeps sticky error status.
module std_lane_rx_buffer
    import pe_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_THRESH = 6,
    parameter int unsigned MAX_PKT_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  reset_poweron,
    input  logic                  std__pe__lane_strm_valid,
    input  logic [1:0]            std__pe__lane_strm_cntl,
    input  logic [DATA_WIDTH-1:0] std__pe__lane_strm_data,
    output logic                  pe__std__lane_strm_ready,
    output logic                  rx__stOp_strm_valid,
    output logic [1:0]            rx__stOp_strm_cntl,
    output logic [DATA_WIDTH-1:0] rx__stOp_strm_data,
    input  logic                  stOp__rx_strm_ready,
    output logic [15:0]           rx__pkt_count,
    output logic                  rx__framing_err,
    output logic                  rx__overflow_err,
    input  logic                  err_clear
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LenW = $clog2(MAX_PKT_LEN) + 1;
    localparam logic [LenW-1:0] LenOne   = LenW'(1);
    localparam logic [LenW-1:0] LenLast  = LenW'(MAX_PKT_LEN - 1);
    localparam logic [AW:0]     AfullThr = (AW+1)'(AFULL_THRESH);

    rx_state_e             state_q, state_d, nxt_state;
    logic [LenW-1:0]       len_q, len_d, nxt_len;
    logic [15:0]           pkt_count_q;
    logic                  ready_q;
    logic                  framing_err_q;
    logic                  overflow_err_q;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic [AW:0]           occupancy;
    logic [AW:0]           occ_next;
    logic [DATA_WIDTH+1:0] head;

    logic                  legal;
    logic                  frame_evt;
    logic                  pkt_evt;
    logic [1:0]            wr_cntl;
    logic                  pop;
    logic                  room;
    logic                  push;
    logic                  framing_set;
    logic                  overflow_set;
    logic                  pkt_inc;

    std_lane_rx_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .push          (push),
        .push_data     ({wr_cntl, std__pe__lane_strm_data}),
        .pop           (pop),
        .head_data     (head),
        .empty         (fifo_empty),
        .full          (fifo_full),
        .occupancy     (occupancy)
    );

    // Framing FSM state register
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q <= StIdle;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    // Next-state decode of the presented word, assuming it gets written
    always_comb begin
        legal     = 1'b0;
        frame_evt = 1'b0;
        pkt_evt   = 1'b0;
        wr_cntl   = std__pe__lane_strm_cntl;
        nxt_state = state_q;
        nxt_len   = len_q;
        unique case (state_q)
            StIdle: begin
                case (std_cntl_e'(std__pe__lane_strm_cntl))
                    CntlSod: begin
                        legal     = 1'b1;
                        nxt_len   = LenOne;
                        nxt_state = StInPkt;
                    end
                    CntlSodEod: begin
                        legal   = 1'b1;
                        pkt_evt = 1'b1;
                        nxt_len = '0;
                    end
                    default: frame_evt = 1'b1;  // Mid/end word outside a packet: dropped
                endcase
            end
            StInPkt: begin
                legal = 1'b1;
                case (std_cntl_e'(std__pe__lane_strm_cntl))
                    CntlMod: begin
                        if (len_q == LenLast) begin
                            // No room left for EOD: close the packet on this word
                            frame_evt = 1'b1;
                            wr_cntl   = STD_CNTL_EOD;
                            pkt_evt   = 1'b1;
                            nxt_state = StIdle;
                            nxt_len   = '0;
                        end else begin
                            nxt_len = len_q + LenOne;
                        end
                    end
                    CntlEod: begin
                        pkt_evt   = 1'b1;
                        nxt_state = StIdle;
                        nxt_len   = '0;
                    end
                    CntlSod: begin
                        // Previous packet is abandoned; new one starts here
                        frame_evt = 1'b1;
                        nxt_len   = LenOne;
                    end
                    default: begin
                        frame_evt = 1'b1;
                        pkt_evt   = 1'b1;
                        nxt_state = StIdle;
                        nxt_len   = '0;
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Accept/drop decisions and commit of the FSM step
    always_comb begin
        pop          = !fifo_empty && stOp__rx_strm_ready;
        room         = !fifo_full || pop;
        push         = std__pe__lane_strm_valid && legal && room;
        overflow_set = std__pe__lane_strm_valid && legal && !room;
        // Overflow-dropped words leave the FSM and framing status untouched
        framing_set  = std__pe__lane_strm_valid && frame_evt && (!legal || room);
        pkt_inc      = push && pkt_evt;
        state_d      = push ? nxt_state : state_q;
        len_d        = push ? nxt_len : len_q;
        occ_next     = occupancy + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    // Registered upstream ready reflects occupancy after this edge
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (occ_next < AfullThr);
        end
    end

    // Completed-packet counter, wraps naturally
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            pkt_count_q <= '0;
        end else if (pkt_inc) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    // Sticky errors; a new error wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            framing_err_q  <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            if (framing_set) begin
                framing_err_q <= 1'b1;
            end else if (err_clear) begin
                framing_err_q <= 1'b0;
            end
            if (overflow_set) begin
                overflow_err_q <= 1'b1;
            end else if (err_clear) begin
                overflow_err_q <= 1'b0;
            end
        end
    end

    // Output mapping
    always_comb begin
        pe__std__lane_strm_ready = ready_q;
        rx__stOp_strm_valid      = !fifo_empty;
        rx__stOp_strm_cntl       = head[DATA_WIDTH+1:DATA_WIDTH];
        rx__stOp_strm_data       = head[DATA_WIDTH-1:0];
        rx__pkt_count            = pkt_count_q;
        rx__framing_err          = framing_err_q;
        rx__overflow_err         = overflow_err_q;
    end

endmodule
